// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX operand/control bundle in, EX/MEM results and stall handshake out
interface ex_stage_if #(parameter int DATA_W = 32, parameter int REG_W = 5);
    logic [5:0]        alu_op_reg;
    logic              reg_dst_reg;
    logic              alu_src_reg;
    logic              mem_write_reg;
    logic              reg_write_reg;
    logic              mem_to_reg_reg;
    logic [DATA_W-1:0] data1_reg;
    logic [DATA_W-1:0] data2_reg;
    logic [DATA_W-1:0] sign_extend_reg;
    logic [REG_W-1:0]  reg1_reg;
    logic [REG_W-1:0]  reg2_reg;
    logic              flush;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  dest_reg;
    logic              mem_write_out;
    logic              reg_write_out;
    logic              mem_to_reg_out;
    logic              stall;
    logic              busy;
    modport slave (
        input  alu_op_reg, reg_dst_reg, alu_src_reg, mem_write_reg, reg_write_reg, mem_to_reg_reg,
               data1_reg, data2_reg, sign_extend_reg, reg1_reg, reg2_reg, flush,
        output alu_result, store_data, dest_reg, mem_write_out, reg_write_out, mem_to_reg_out,
               stall, busy
    );
    modport master (
        output alu_op_reg, reg_dst_reg, alu_src_reg, mem_write_reg, reg_write_reg, mem_to_reg_reg,
               data1_reg, data2_reg, sign_extend_reg, reg1_reg, reg2_reg, flush,
        input  alu_result, store_data, dest_reg, mem_write_out, reg_write_out, mem_to_reg_out,
               stall, busy
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: execute stage with single-cycle ALU and iterative MULT/DIVU that stalls the front end
module ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input logic      clk,
    input logic      rst,
    ex_stage_if.slave io
);
    localparam int CW = $clog2(DATA_W);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_n;
    logic [DATA_W-1:0] op_b, alu_y, long_y, x, y;
    logic [DATA_W:0]   acc, r_sh, diff;
    logic [CW-1:0]     cnt;
    logic [4:0]        shamt;
    logic              is_mul, is_div, is_long, div_q, hold, start;
    assign op_b    = io.alu_src_reg ? io.sign_extend_reg : io.data2_reg;
    assign shamt   = io.sign_extend_reg[10:6];
    assign is_mul  = io.alu_op_reg == 6'h18;
    assign is_div  = io.alu_op_reg == 6'h1A;
    assign is_long = is_mul || is_div;
    always_comb begin
        alu_y = '0;
        case (io.alu_op_reg)
            6'h20:   alu_y = io.data1_reg + op_b;
            6'h22:   alu_y = io.data1_reg - op_b;
            6'h24:   alu_y = io.data1_reg & op_b;
            6'h25:   alu_y = io.data1_reg | op_b;
            6'h26:   alu_y = io.data1_reg ^ op_b;
            6'h27:   alu_y = ~(io.data1_reg | op_b);
            6'h2A:   alu_y = {{(DATA_W-1){1'b0}}, $signed(io.data1_reg) < $signed(op_b)};
            6'h00:   alu_y = op_b << shamt;
            6'h02:   alu_y = op_b >> shamt;
            default: alu_y = '0;
        endcase
    end
    always_comb begin
        state_n = state;
        if (io.flush) state_n = IDLE;
        else if (state == IDLE) state_n = is_long ? BUSY : IDLE;
        else if (state == BUSY) state_n = (cnt == CW'(DATA_W-1)) ? DONE : BUSY;
        else state_n = IDLE;
    end
    // hold covers the issue cycle too, so the front end freezes before the first edge
    assign hold     = state == BUSY || (state == IDLE && is_long);
    assign start    = state == IDLE && is_long && !io.flush;
    assign io.stall = !rst && !io.flush && hold;
    assign io.busy  = state == BUSY;
    // restoring divide: x shifts the dividend out and the quotient in
    assign r_sh   = {acc[DATA_W-1:0], x[DATA_W-1]};
    assign diff   = r_sh - {1'b0, y};
    assign long_y = div_q ? x : acc[DATA_W-1:0];
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x     <= '0;
            y     <= '0;
            acc   <= '0;
            cnt   <= '0;
            div_q <= 1'b0;
        end else if (start) begin
            x     <= is_div ? io.data1_reg : op_b;
            y     <= is_div ? op_b : io.data1_reg;
            acc   <= '0;
            cnt   <= '0;
            div_q <= is_div;
        end else if (state == BUSY) begin
            cnt <= cnt + 1'b1;
            if (div_q) begin
                acc <= diff[DATA_W] ? r_sh : diff;
                x   <= {x[DATA_W-2:0], !diff[DATA_W]};
            end else begin
                acc <= acc + {1'b0, y & {DATA_W{x[0]}}};
                x   <= x >> 1;
                y   <= y << 1;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst || io.flush || hold) begin
            io.alu_result     <= '0;
            io.store_data     <= '0;
            io.dest_reg       <= '0;
            io.mem_write_out  <= 1'b0;
            io.reg_write_out  <= 1'b0;
            io.mem_to_reg_out <= 1'b0;
        end else begin
            io.alu_result     <= state == DONE ? long_y : alu_y;
            io.store_data     <= io.data2_reg;
            io.dest_reg       <= io.reg_dst_reg ? io.reg2_reg : io.reg1_reg;
            io.mem_write_out  <= io.mem_write_reg;
            io.reg_write_out  <= io.reg_write_reg;
            io.mem_to_reg_out <= io.mem_to_reg_reg;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: table-driven ALU vectors plus scoreboarded MULT/DIVU, flush and reset sequences
module tb_ex_stage;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;
    ex_stage_if #(.DATA_W(32), .REG_W(5)) ifc ();
    ex_stage #(.DATA_W(32), .REG_W(5)) dut (.clk(clk), .rst(rst), .io(ifc.slave));
    typedef struct {
        logic [5:0]  op;
        logic        src, dst, mw, rw, mr;
        logic [31:0] a, b, se;
        logic [4:0]  r1, r2;
        logic [31:0] res;
    } vec_t;
    typedef struct {
        logic [31:0] res, st;
        logic [4:0]  dest;
        logic        mw, rw, mr;
    } exp_t;
    exp_t sb[$];
    vec_t tbl[14];
    int checks = 0;
    int errors = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask
    function automatic exp_t expect_of(input vec_t v);
        exp_t e;
        e.res  = v.res;
        e.st   = v.b;
        e.dest = v.dst ? v.r2 : v.r1;
        e.mw   = v.mw;
        e.rw   = v.rw;
        e.mr   = v.mr;
        return e;
    endfunction
    task automatic drive(input vec_t v);
        ifc.alu_op_reg      = v.op;
        ifc.alu_src_reg     = v.src;
        ifc.reg_dst_reg     = v.dst;
        ifc.mem_write_reg   = v.mw;
        ifc.reg_write_reg   = v.rw;
        ifc.mem_to_reg_reg  = v.mr;
        ifc.data1_reg       = v.a;
        ifc.data2_reg       = v.b;
        ifc.sign_extend_reg = v.se;
        ifc.reg1_reg        = v.r1;
        ifc.reg2_reg        = v.r2;
    endtask
    task automatic compare_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".res"}, ifc.alu_result, e.res);
        chk({tag, ".store"}, ifc.store_data, e.st);
        chk({tag, ".dest"}, 32'(ifc.dest_reg), 32'(e.dest));
        chk({tag, ".ctl"}, {29'd0, ifc.mem_write_out, ifc.reg_write_out, ifc.mem_to_reg_out},
            {29'd0, e.mw, e.rw, e.mr});
    endtask
    function automatic vec_t mk(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res);
        vec_t v;
        v = '{op, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, a, b, 32'd0, 5'd2, 5'd9, res};
        return v;
    endfunction
    // issue a long op, count stall cycles, check bubbles, then compare the result
    task automatic run_long(input string tag, input vec_t v);
        int n = 0;
        int bad = 0;
        @(negedge clk);
        drive(v);
        sb.push_back(expect_of(v));
        #1;
        while (ifc.stall && n < 100) begin
            n++;
            @(posedge clk);
            #1;
            if (ifc.reg_write_out !== 1'b0 || ifc.alu_result !== 32'd0) bad++;
        end
        chk({tag, ".stall_cycles"}, n, 33);
        chk({tag, ".bubbles"}, bad, 0);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask
    vec_t nop, v;
    initial begin
        nop = '{6'h3F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        ifc.flush = 0;
        drive(nop);
        tbl[0]  = '{6'h20, 0, 1, 0, 1, 0, 32'd5, 32'd4, 32'd0, 5'd0, 5'd1, 32'd9};
        tbl[1]  = '{6'h20, 1, 1, 0, 1, 0, 32'd5, 32'd4, 32'd3, 5'd0, 5'd1, 32'd8};
        tbl[2]  = '{6'h22, 0, 0, 1, 0, 0, 32'd5, 32'd7, 32'd0, 5'd3, 5'd4, 32'hFFFF_FFFE};
        tbl[3]  = '{6'h24, 0, 1, 0, 1, 1, 32'hF0F0, 32'hFF00, 32'd0, 5'd6, 5'd7, 32'hF000};
        tbl[4]  = '{6'h25, 0, 1, 0, 1, 0, 32'hF0F0, 32'hFF00, 32'd0, 5'd6, 5'd8, 32'hFFF0};
        tbl[5]  = '{6'h26, 0, 1, 0, 1, 0, 32'hF0F0, 32'hFF00, 32'd0, 5'd6, 5'd10, 32'h0FF0};
        tbl[6]  = '{6'h27, 0, 1, 0, 1, 0, 32'd0, 32'd0, 32'd0, 5'd6, 5'd11, 32'hFFFF_FFFF};
        tbl[7]  = '{6'h2A, 0, 1, 0, 1, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0, 5'd12, 32'd1};
        tbl[8]  = '{6'h2A, 0, 1, 0, 1, 0, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd0, 5'd13, 32'd0};
        tbl[9]  = '{6'h00, 0, 1, 0, 1, 0, 32'd0, 32'd1, 32'h7C0, 5'd0, 5'd14, 32'h8000_0000};
        tbl[10] = '{6'h02, 0, 1, 0, 1, 0, 32'd0, 32'h8000_0000, 32'h7C0, 5'd0, 5'd15, 32'd1};
        tbl[11] = '{6'h00, 0, 1, 0, 1, 0, 32'd0, 32'h3, 32'h100, 5'd0, 5'd16, 32'h30};
        tbl[12] = '{6'h3F, 0, 0, 0, 1, 1, 32'd7, 32'd8, 32'd0, 5'd17, 5'd18, 32'd0};
        tbl[13] = '{6'h20, 0, 1, 0, 1, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0, 5'd19, 32'd0};
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset.res", ifc.alu_result, 0);
        chk("reset.busy_stall", {30'd0, ifc.busy, ifc.stall}, 0);
        @(negedge clk);
        rst = 0;
        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            sb.push_back(expect_of(tbl[i]));
            #1;
            chk($sformatf("vec%0d.stall", i), 32'(ifc.stall), 0);
            @(posedge clk);
            #1;
            compare_out($sformatf("vec%0d", i));
        end
        run_long("mult7x6", mk(6'h18, 32'd7, 32'd6, 32'd42));
        run_long("divu100_7", mk(6'h1A, 32'd100, 32'd7, 32'd14));
        run_long("divu_by0", mk(6'h1A, 32'd12345, 32'd0, 32'hFFFF_FFFF));
        run_long("mult_wrap", mk(6'h18, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE));
        run_long("divu_big", mk(6'h1A, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF));
        run_long("mult3x3", mk(6'h18, 32'd3, 32'd3, 32'd9));
        run_long("mult4x4", mk(6'h18, 32'd4, 32'd4, 32'd16));
        @(negedge clk);
        drive(nop);
        @(posedge clk);
        #1;
        chk("b2b.no_reissue", {30'd0, ifc.busy, ifc.stall}, 0);
        // flush a MULT partway through its iterations
        @(negedge clk);
        drive(mk(6'h18, 32'd5, 32'd5, 32'd25));
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("flush.pre_busy", 32'(ifc.busy), 1);
        ifc.flush = 1;
        sb.push_back('{32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0});
        #1;
        chk("flush.stall", 32'(ifc.stall), 0);
        @(posedge clk);
        #1;
        compare_out("flush.bubble");
        chk("flush.busy", 32'(ifc.busy), 0);
        @(negedge clk);
        ifc.flush = 0;
        v = mk(6'h20, 32'd10, 32'd20, 32'd30);
        drive(v);
        sb.push_back(expect_of(v));
        #1;
        chk("post_flush.stall", 32'(ifc.stall), 0);
        @(posedge clk);
        #1;
        compare_out("post_flush.add");
        // asynchronous reset in the middle of a MULT
        @(negedge clk);
        drive(mk(6'h18, 32'd9, 32'd9, 32'd81));
        repeat (11) @(posedge clk);
        #1;
        chk("rst.pre_busy", 32'(ifc.busy), 1);
        #2;
        rst = 1;
        #1;
        chk("rst.busy", 32'(ifc.busy), 0);
        chk("rst.outs", ifc.alu_result | 32'(ifc.dest_reg) |
            32'({ifc.reg_write_out, ifc.mem_write_out, ifc.mem_to_reg_out}), 0);
        @(negedge clk);
        rst = 0;
        v = mk(6'h25, 32'h10, 32'h01, 32'h11);
        drive(v);
        sb.push_back(expect_of(v));
        #1;
        chk("rst.release_stall", 32'(ifc.stall), 0);
        @(posedge clk);
        #1;
        compare_out("rst.or");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage: the consumer side of the ID/EX pipeline register.
- Takes the registered decode outputs (ALU op, control bits, operands, sign-extended immediate, register specifiers) and selects operand B and the destination register.
- Computes single-cycle ALU results, plus iterative multiply/divide under an FSM with a stall handshake back to the front end.
- Drives its own registered EX/MEM outputs.

Parameters:
DATA_W, 32, operand/result width; also the iteration count for MULT/DIVU
REG_W, 5, register specifier width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
alu_op_reg  in  6  ALU operation from ID/EX
reg_dst_reg  in  1  1: dest = reg2_reg... see Behaviour
alu_src_reg  in  1  1: operand B = sign_extend_reg, 0: data2_reg
mem_write_reg  in  1  store control
reg_write_reg  in  1  writeback control
mem_to_reg_reg  in  1  load-select control
data1_reg  in  DATA_W  operand A
data2_reg  in  DATA_W  operand B / store data
sign_extend_reg  in  DATA_W  immediate; bits [10:6] = shamt
reg1_reg  in  REG_W  rt specifier
reg2_reg  in  REG_W  rd specifier
flush  in  1  synchronous squash of the current EX instruction
alu_result  out  DATA_W  registered result
store_data  out  DATA_W  registered data2_reg
dest_reg  out  REG_W  registered destination
mem_write_out  out  1  registered control
reg_write_out  out  1  registered control
mem_to_reg_out  out  1  registered control
stall  out  1  combinational; front end holds PC/IF-ID/ID-EX while high
busy  out  1  registered; FSM in BUSY

Behaviour:
- Reset (async, active-high):
  - All registered outputs are 0.
  - busy = 0; FSM = IDLE; iteration counter = 0.
  - Any in-flight MULT/DIVU is discarded.
- dest_reg source: reg2_reg when reg_dst_reg = 1, else reg1_reg.
- Operand B: sign_extend_reg when alu_src_reg = 1, else data2_reg.
- alu_op encoding (all arithmetic mod 2^DATA_W):
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR.
  - 0x2A SLT: signed compare, result 1 or 0.
  - 0x00 SLL, 0x02 SRL: B shifted by sign_extend_reg[10:6].
  - 0x18 MULT: low DATA_W bits of the unsigned product.
  - 0x1A DIVU: unsigned quotient.
  - Any other code: result 0, controls still pass through.
- Single-cycle ops: 1-cycle latency. Outputs update at the edge following input presentation.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, op is MULT/DIVU, no flush: stall = 1. Next edge: load operands, counter = 0, go to BUSY. Output latch loads a bubble (all three controls 0, data fields 0).
  - BUSY: stall = 1. One shift-add (MULT) or restoring-subtract (DIVU) step per edge. Output latch loads a bubble every edge. When counter = DATA_W-1, go to DONE.
  - DONE: stall = 0. Next edge: output latch captures the result and live controls; go to IDLE.
  - The instruction still present in DONE does not retrigger.
- Timing: with DATA_W = 32 and the op presented in cycle 0, stall is high in cycles 0–32 and low in cycle 33. Result is visible after the edge ending cycle 33.
- DIVU by zero: quotient = all ones, no exception.
- flush = 1 at an edge:
  - Output latch loads a bubble.
  - FSM goes to IDLE and any BUSY/DONE operation is aborted.
  - stall is forced to 0 that cycle.
- Flush has priority over normal loading. Reset has priority over everything.
- Back-to-back MULT: the second op starts from IDLE after DONE, so a new 33-cycle stall window follows.

Test Plan:
1. rst = 1 mid-BUSY (after 10 MULT iterations) -> all outputs and busy read 0 immediately (before next edge); FSM IDLE; stall = 0 once rst releases with a non-long op presented.
2. ADD, data1 = 5, data2 = 4, alu_src = 0, reg_dst = 1, reg2 = 1, reg_write = 1 -> after one edge: alu_result = 9, dest_reg = 1, reg_write_out = 1; with alu_src = 1 and sign_extend = 3 -> alu_result = 8.
3. SLT, data1 = 0xFFFFFFFF, data2 = 1 -> result 1. SLL, data2 = 1, sign_extend[10:6] = 31 -> result 0x80000000.
4. MULT, 7 × 6, reg_write = 1 -> stall high for exactly 33 cycles; bubbles (reg_write_out = 0) during them; then alu_result = 42 with reg_write_out = 1. DIVU 100/7 -> 14. DIVU x/0 -> 0xFFFFFFFF.
5. flush asserted in BUSY cycle 5 of a MULT -> next edge: bubble, busy = 0, stall = 0; the following ADD completes in 1 cycle.
6. Two consecutive MULTs (3×3 then 4×4) -> results 9 then 16, with a separate 33-cycle stall window for each and no double issue.
